// File: rtl/peak_readout_serializer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// peak_readout_serializer_if: valid/ready stream carrying one pixel peak per beat.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface peak_readout_serializer_if #(
  parameter int NP          = 10,
  parameter int PIX_NUM     = 3,
  parameter int FRAME_CNT_W = 8
);
  localparam int PW = (PIX_NUM > 1) ? $clog2(PIX_NUM) : 1;

  logic                   outValid;
  logic                   outReady;
  logic [NP-1:0]          outPeak;
  logic [PW-1:0]          outPixel;
  logic                   outLast;
  logic                   outNoHit;
  logic [FRAME_CNT_W-1:0] outFrame;

  modport master (
    output outValid, outPeak, outPixel, outLast, outNoHit, outFrame,
    input  outReady
  );

  modport slave (
    input  outValid, outPeak, outPixel, outLast, outNoHit, outFrame,
    output outReady
  );
endinterface
`default_nettype wire

// File: rtl/peak_readout_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// peak_readout_serializer: snapshots per-frame peak bins, streams one pixel per beat.
// Optional TEMPORAL_AVG_EN: averages each nonzero pixel with its last sent raw value.
// Revision: 1.0
// ---------------------------------------------------------------------------
module peak_readout_serializer #(
  parameter int NP          = 10,
  parameter int PIX_NUM     = 3,
  parameter int FRAME_CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      res,
  input  logic                      peakValid,
  input  logic [NP*PIX_NUM-1:0]     peakIn,
  peak_readout_serializer_if.master stream,
  output logic                      overrun,
  output logic                      busy
);
  localparam int PW = (PIX_NUM > 1) ? $clog2(PIX_NUM) : 1;
  localparam logic [PW-1:0] LAST_PIX = PW'(PIX_NUM - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    NEXT = 2'd2
  } state_t;

  state_t                 state;
  logic [NP-1:0]          in_pix   [PIX_NUM];
  logic [NP-1:0]          act_buf  [PIX_NUM];
  logic [NP-1:0]          pend_buf [PIX_NUM];
  logic                   pend_full;
  logic [PW-1:0]          pixel;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic                   out_valid;
  logic                   out_last;
  logic [NP-1:0]          out_peak;

  logic                   accept;
  logic                   reload;
  logic [PW-1:0]          nxt_idx;
  logic [NP-1:0]          first_in;
  logic [NP-1:0]          first_pend;
  logic [NP-1:0]          next_act;

  for (genvar k = 0; k < PIX_NUM; k++) begin : g_unpack
    assign in_pix[k] = peakIn[k*NP +: NP];
  end

  assign accept  = out_valid & stream.outReady;
  assign reload  = (state == NEXT) && pend_full;
  assign nxt_idx = (pixel == LAST_PIX) ? LAST_PIX : pixel + 1'b1;

`ifdef TEMPORAL_AVG_EN
  logic [NP-1:0]      hist [PIX_NUM];
  logic [PIX_NUM-1:0] hist_valid;

  function automatic logic [NP-1:0] shape(input logic [NP-1:0] cur,
                                          input logic [NP-1:0] h,
                                          input logic          hv);
    logic [NP:0] sum;
    sum = {1'b0, h} + {1'b0, cur} + {{NP{1'b0}}, 1'b1};
    if (cur == '0) return '0;
    if (!hv)       return cur;
    return sum[NP:1];
  endfunction

  assign first_in   = shape(in_pix[0],         hist[0],       hist_valid[0]);
  assign first_pend = shape(pend_buf[0],       hist[0],       hist_valid[0]);
  assign next_act   = shape(act_buf[nxt_idx],  hist[nxt_idx], hist_valid[nxt_idx]);

  // History holds the raw value of the last accepted nonzero beat per pixel.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      hist_valid <= '0;
      for (int k = 0; k < PIX_NUM; k++) hist[k] <= '0;
    end else if (state == SEND && accept && act_buf[pixel] != '0) begin
      hist[pixel]       <= act_buf[pixel];
      hist_valid[pixel] <= 1'b1;
    end
  end
`else
  assign first_in   = in_pix[0];
  assign first_pend = pend_buf[0];
  assign next_act   = act_buf[nxt_idx];
`endif

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_peak  <= '0;
      out_last  <= 1'b0;
      pixel     <= '0;
      frame_cnt <= '0;
      pend_full <= 1'b0;
      overrun   <= 1'b0;
      for (int k = 0; k < PIX_NUM; k++) begin
        act_buf[k]  <= '0;
        pend_buf[k] <= '0;
      end
    end else begin
      // NEXT with nothing pending loads a new frame straight into the active slot.
      if (peakValid && state != IDLE && !(state == NEXT && !pend_full)) begin
        if (!pend_full || reload) begin
          pend_buf  <= in_pix;
          pend_full <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (peakValid) begin
            act_buf   <= in_pix;
            out_peak  <= first_in;
            pixel     <= '0;
            out_last  <= (PIX_NUM == 1);
            out_valid <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (accept) begin
            if (pixel != LAST_PIX) begin
              pixel    <= nxt_idx;
              out_peak <= next_act;
              out_last <= (nxt_idx == LAST_PIX);
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= NEXT;
            end
          end
        end
        NEXT: begin
          if (pend_full) begin
            act_buf   <= pend_buf;
            out_peak  <= first_pend;
            pixel     <= '0;
            out_last  <= (PIX_NUM == 1);
            out_valid <= 1'b1;
            state     <= SEND;
            if (!peakValid) pend_full <= 1'b0;
          end else if (peakValid) begin
            act_buf   <= in_pix;
            out_peak  <= first_in;
            pixel     <= '0;
            out_last  <= (PIX_NUM == 1);
            out_valid <= 1'b1;
            state     <= SEND;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stream.outValid = out_valid;
  assign stream.outPeak  = out_peak;
  assign stream.outPixel = pixel;
  assign stream.outLast  = out_last;
  assign stream.outNoHit = out_valid & (out_peak == '0);
  assign stream.outFrame = frame_cnt;
  assign busy            = (state != IDLE) | pend_full;
endmodule
`default_nettype wire
